// File: rtl/game_pkg.sv
// Shared game constants and types for the race-track blocks.
package game_pkg;

    localparam int CLK_HZ = 50_000_000;

    localparam int QBLOCK_NUM       = 4;
    localparam int QBLOCK_IDX_WIDTH = 2;

    localparam int QBLOCK_REGENERATE_INTERVAL       = 10;
    localparam int QBLOCK_REGENERATE_INTERVAL_WIDTH = 4;

    typedef enum logic {
        QBLOCK_PRESENT,
        QBLOCK_RESPAWN
    } QblockState;

endpackage

// File: rtl/qblock_tick_gen.sv
// One-second tick prescaler; held at zero while the race is stopped.
module qblock_tick_gen
    import game_pkg::*;
#(
    parameter int CLK_HZ = game_pkg::CLK_HZ
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_enable,
    output logic o_tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (!i_enable || cnt == TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_tick = i_enable && (cnt == TERM);

endmodule

// File: rtl/qblock_arbiter.sv
// Grants each ?-block pickup to one car, hides it, and regenerates it
// after REGEN_S ticks. Same-block contention alternates between cars.
module qblock_arbiter
    import game_pkg::*;
#(
    parameter int CLK_HZ     = game_pkg::CLK_HZ,
    parameter int QBLOCK_NUM = game_pkg::QBLOCK_NUM,
    parameter int REGEN_S    = QBLOCK_REGENERATE_INTERVAL
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_game_run,
    input  logic [QBLOCK_NUM-1:0]       i_car1_hit,
    input  logic [QBLOCK_NUM-1:0]       i_car2_hit,
    output logic [QBLOCK_NUM-1:0]       o_qblock_visible,
    output logic                        o_car1_grant,
    output logic [QBLOCK_IDX_WIDTH-1:0] o_car1_grant_idx,
    output logic                        o_car2_grant,
    output logic [QBLOCK_IDX_WIDTH-1:0] o_car2_grant_idx
);

    localparam int CW = QBLOCK_REGENERATE_INTERVAL_WIDTH;
    localparam logic [CW-1:0] REGEN_V = CW'(REGEN_S);

    QblockState state      [QBLOCK_NUM];
    QblockState state_next [QBLOCK_NUM];
    logic [CW-1:0] cnt      [QBLOCK_NUM];
    logic [CW-1:0] cnt_next [QBLOCK_NUM];

    logic prio, prio_next;
    logic grant1, grant1_next, grant2, grant2_next;
    logic [QBLOCK_IDX_WIDTH-1:0] idx1, idx1_next, idx2, idx2_next;

    logic [QBLOCK_NUM-1:0] elig1, elig2;
    logic found1, found2, take1, take2;
    logic [QBLOCK_IDX_WIDTH-1:0] sel1, sel2;
    logic tick;

    qblock_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_enable (i_game_run),
        .o_tick   (tick)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < QBLOCK_NUM; k++) begin
                state[k] <= QBLOCK_PRESENT;
                cnt[k]   <= '0;
            end
            prio   <= 1'b0;
            grant1 <= 1'b0;
            grant2 <= 1'b0;
            idx1   <= '0;
            idx2   <= '0;
        end else begin
            for (int k = 0; k < QBLOCK_NUM; k++) begin
                state[k] <= state_next[k];
                cnt[k]   <= cnt_next[k];
            end
            prio   <= prio_next;
            grant1 <= grant1_next;
            grant2 <= grant2_next;
            idx1   <= idx1_next;
            idx2   <= idx2_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        prio_next   = prio;
        grant1_next = 1'b0;
        grant2_next = 1'b0;
        idx1_next   = idx1;
        idx2_next   = idx2;
        elig1       = '0;
        elig2       = '0;
        found1      = 1'b0;
        found2      = 1'b0;
        sel1        = '0;
        sel2        = '0;

        for (int k = 0; k < QBLOCK_NUM; k++) begin
            if (i_game_run && state[k] == QBLOCK_PRESENT) begin
                elig1[k] = i_car1_hit[k];
                elig2[k] = i_car2_hit[k];
            end
        end

        // Descending scan leaves the lowest eligible index selected.
        for (int k = QBLOCK_NUM - 1; k >= 0; k--) begin
            if (elig1[k]) begin
                found1 = 1'b1;
                sel1   = QBLOCK_IDX_WIDTH'(k);
            end
            if (elig2[k]) begin
                found2 = 1'b1;
                sel2   = QBLOCK_IDX_WIDTH'(k);
            end
        end

        take1 = found1;
        take2 = found2;
        if (found1 && found2 && sel1 == sel2) begin
            if (prio) take1 = 1'b0;
            else      take2 = 1'b0;
            prio_next = ~prio;
        end

        if (tick) begin
            for (int k = 0; k < QBLOCK_NUM; k++) begin
                if (state[k] == QBLOCK_RESPAWN) begin
                    if (cnt[k] == CW'(1)) begin
                        state_next[k] = QBLOCK_PRESENT;
                        cnt_next[k]   = '0;
                    end else begin
                        cnt_next[k] = cnt[k] - 1'b1;
                    end
                end
            end
        end

        // A fresh pickup overrides any decrement from a coincident tick.
        if (take1) begin
            state_next[sel1] = QBLOCK_RESPAWN;
            cnt_next[sel1]   = REGEN_V;
            grant1_next      = 1'b1;
            idx1_next        = sel1;
        end
        if (take2) begin
            state_next[sel2] = QBLOCK_RESPAWN;
            cnt_next[sel2]   = REGEN_V;
            grant2_next      = 1'b1;
            idx2_next        = sel2;
        end

        if (!i_game_run) begin
            for (int k = 0; k < QBLOCK_NUM; k++) begin
                state_next[k] = QBLOCK_PRESENT;
                cnt_next[k]   = '0;
            end
            prio_next   = 1'b0;
            grant1_next = 1'b0;
            grant2_next = 1'b0;
        end
    end

    always_comb begin
        o_qblock_visible = '0;
        for (int k = 0; k < QBLOCK_NUM; k++) begin
            o_qblock_visible[k] = (state[k] == QBLOCK_PRESENT);
        end
    end

    assign o_car1_grant     = grant1;
    assign o_car1_grant_idx = idx1;
    assign o_car2_grant     = grant2;
    assign o_car2_grant_idx = idx2;

endmodule

// File: tb/tb_qblock_arbiter.sv
// Directed bench for qblock_arbiter with a 10-cycle tick and 3-tick regeneration.
module tb_qblock_arbiter;

    localparam int TB_HZ    = 10;
    localparam int TB_REGEN = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       game_run = 1'b0;
    logic [3:0] car1_hit = '0;
    logic [3:0] car2_hit = '0;
    logic [3:0] qblock_visible;
    logic       car1_grant, car2_grant;
    logic [1:0] car1_grant_idx, car2_grant_idx;

    int n_cmp = 0;
    int n_bad = 0;
    int ecount = 0;
    int c0;

    qblock_arbiter #(
        .CLK_HZ     (TB_HZ),
        .QBLOCK_NUM (4),
        .REGEN_S    (TB_REGEN)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_game_run       (game_run),
        .i_car1_hit       (car1_hit),
        .i_car2_hit       (car2_hit),
        .o_qblock_visible (qblock_visible),
        .o_car1_grant     (car1_grant),
        .o_car1_grant_idx (car1_grant_idx),
        .o_car2_grant     (car2_grant),
        .o_car2_grant_idx (car2_grant_idx)
    );

    always #5 clk = ~clk;

    // Edges seen while running since the last stop or reset: the tick phase.
    always @(posedge clk or posedge rst) begin
        if (rst)           ecount <= 0;
        else if (!game_run) ecount <= 0;
        else               ecount <= ecount + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic outs(input string tag, input logic [3:0] vis, input logic g1, input logic [1:0] i1,
                        input logic g2, input logic [1:0] i2);
        chk({tag, "_vis"}, qblock_visible, vis);
        chk({tag, "_g1"}, car1_grant, g1);
        if (g1) chk({tag, "_i1"}, car1_grant_idx, i1);
        chk({tag, "_g2"}, car2_grant, g2);
        if (g2) chk({tag, "_i2"}, car2_grant_idx, i2);
    endtask

    // Called right after the pickup edge; expects regeneration on the third tick.
    task automatic wait_regen(input int blk, input int pre, input string tag);
        int d1, exp_n, n;
        logic seen_grant, done;
        d1 = (TB_HZ - 1 - pre + TB_HZ) % TB_HZ;
        if (d1 == 0) d1 = TB_HZ;
        exp_n = d1 + (TB_REGEN - 1) * TB_HZ;
        n = 0;
        seen_grant = 1'b0;
        done = 1'b0;
        while (!done && n <= 40) begin
            @(negedge clk);
            n++;
            if (car1_grant || car2_grant) seen_grant = 1'b1;
            if (qblock_visible[blk]) done = 1'b1;
        end
        chk({tag, "_delay"}, n, exp_n);
        chk({tag, "_quiet"}, {31'd0, seen_grant}, 0);
    endtask

    initial begin
        step();
        step();
        outs("reset", 4'b1111, 1'b0, 2'd0, 1'b0, 2'd0);
        chk("reset_i1", car1_grant_idx, 0);
        chk("reset_i2", car2_grant_idx, 0);
        rst = 1'b0;

        car1_hit = 4'b1111;
        car2_hit = 4'b1111;
        step();
        outs("idle_a", 4'b1111, 1'b0, 2'd0, 1'b0, 2'd0);
        step();
        outs("idle_b", 4'b1111, 1'b0, 2'd0, 1'b0, 2'd0);

        car1_hit = '0;
        car2_hit = '0;
        game_run = 1'b1;
        step();
        car1_hit = 4'b0100;
        step();
        outs("single", 4'b1011, 1'b1, 2'd2, 1'b0, 2'd0);
        c0 = (ecount - 1) % TB_HZ;
        car1_hit = '0;
        wait_regen(2, c0, "single_regen");
        chk("single_vis_back", qblock_visible, 4'b1111);

        car1_hit = 4'b0001;
        step();
        outs("pre_rst", 4'b1110, 1'b1, 2'd0, 1'b0, 2'd0);
        car1_hit = '0;
        rst = 1'b1;
        #2;
        outs("rst_mid", 4'b1111, 1'b0, 2'd0, 1'b0, 2'd0);
        step();
        rst = 1'b0;

        car1_hit = 4'b0001;
        car2_hit = 4'b0001;
        step();
        outs("cont1", 4'b1110, 1'b1, 2'd0, 1'b0, 2'd0);
        c0 = (ecount - 1) % TB_HZ;
        car1_hit = '0;
        car2_hit = '0;
        wait_regen(0, c0, "cont1_regen");

        car1_hit = 4'b0001;
        car2_hit = 4'b0001;
        step();
        outs("cont2", 4'b1110, 1'b0, 2'd0, 1'b1, 2'd0);
        c0 = (ecount - 1) % TB_HZ;
        car1_hit = '0;
        car2_hit = '0;
        wait_regen(0, c0, "cont2_regen");

        car1_hit = 4'b0001;
        car2_hit = 4'b0001;
        step();
        outs("cont3", 4'b1110, 1'b1, 2'd0, 1'b0, 2'd0);
        c0 = (ecount - 1) % TB_HZ;
        car1_hit = '0;
        car2_hit = '0;
        wait_regen(0, c0, "cont3_regen");

        car1_hit = 4'b1010;
        car2_hit = 4'b0100;
        step();
        outs("multi_a", 4'b1001, 1'b1, 2'd1, 1'b1, 2'd2);
        step();
        outs("multi_b", 4'b0001, 1'b1, 2'd3, 1'b0, 2'd0);
        car1_hit = '0;
        car2_hit = '0;
        step();
        outs("multi_c", 4'b0001, 1'b0, 2'd0, 1'b0, 2'd0);

        game_run = 1'b0;
        step();
        outs("stop_clear", 4'b1111, 1'b0, 2'd0, 1'b0, 2'd0);
        game_run = 1'b1;
        car1_hit = 4'b1000;
        step();
        outs("stop_pick", 4'b0111, 1'b1, 2'd3, 1'b0, 2'd0);
        car1_hit = '0;
        repeat (4) step();
        outs("stop_wait", 4'b0111, 1'b0, 2'd0, 1'b0, 2'd0);
        game_run = 1'b0;
        car2_hit = 4'b1000;
        step();
        outs("stop_drop", 4'b1111, 1'b0, 2'd0, 1'b0, 2'd0);
        game_run = 1'b1;
        step();
        outs("stop_rerun", 4'b0111, 1'b0, 2'd0, 1'b1, 2'd3);
        car1_hit = 4'b0001;
        car2_hit = 4'b0001;
        step();
        outs("stop_prio", 4'b0110, 1'b1, 2'd0, 1'b0, 2'd0);
        car1_hit = '0;
        car2_hit = '0;

        game_run = 1'b0;
        step();
        outs("hold_clear", 4'b1111, 1'b0, 2'd0, 1'b0, 2'd0);
        game_run = 1'b1;
        car2_hit = 4'b0010;
        step();
        outs("hold_g0", 4'b1101, 1'b0, 2'd0, 1'b1, 2'd1);
        c0 = (ecount - 1) % TB_HZ;
        wait_regen(1, c0, "hold_r1");
        step();
        outs("hold_g1", 4'b1101, 1'b0, 2'd0, 1'b1, 2'd1);
        c0 = (ecount - 1) % TB_HZ;
        wait_regen(1, c0, "hold_r2");
        step();
        outs("hold_g2", 4'b1101, 1'b0, 2'd0, 1'b1, 2'd1);
        step();
        outs("hold_after", 4'b1101, 1'b0, 2'd0, 1'b0, 2'd0);
        car2_hit = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/qblock_arbiter.md
# qblock_arbiter

Owns the lifecycle of the four ?-blocks on the race track. Grants each pickup to exactly one car, hides a picked block, and regenerates it after a fixed interval. Sits between the per-block car/qblock overlap detectors and both the renderer (block visibility) and the car-state logic (item grant pulses). Resolves contention when both cars touch the same block in the same cycle.

## Interface
- `CLK_HZ`, 50_000_000: clock frequency; sets the one-second tick period.
- `QBLOCK_NUM`, 4: number of blocks.
- `REGEN_S`, 10: regeneration interval in seconds; must fit in 4 bits.

Ports:
- `i_clk`, in, 1: system clock; sole clock domain.
- `i_rst`, in, 1: reset, asynchronous, active-high.
- `i_game_run`, in, 1: race in progress. When low, the block is held in its idle state.
- `i_car1_hit`, in, QBLOCK_NUM: level, car1 overlaps block k.
- `i_car2_hit`, in, QBLOCK_NUM: level, car2 overlaps block k.
- `o_qblock_visible`, out, QBLOCK_NUM: block k is present and drawn.
- `o_car1_grant`, out, 1: one-cycle pulse, car1 picked up a block.
- `o_car1_grant_idx`, out, 2: index of that block; valid only with the grant.
- `o_car2_grant`, out, 1: one-cycle pulse, car2 picked up a block.
- `o_car2_grant_idx`, out, 2: index of that block; valid only with the grant.

## Operation
- **Per-block state:** `PRESENT` (visible=1) or `RESPAWN` (visible=0, 4-bit countdown).
- **Eligibility:** a hit on block k is eligible only while k is `PRESENT` and `i_game_run`=1. Hits on `RESPAWN` blocks are ignored.
- **Per-car selection:** each car takes the lowest-index eligible hit. Each car receives at most one grant per cycle. Its other eligible hits stay `PRESENT` and are re-evaluated next cycle.
- **Contention:** if both cars select the same block, the priority flag picks the winner (0 = car1, 1 = car2). The flag toggles after every contested grant. The loser gets no grant that cycle; its next-lowest eligible hit is considered the following cycle.
- **Distinct blocks:** both cars may be granted in the same cycle if they selected different blocks.
- **On grant of block k:** k goes to `RESPAWN` with countdown=REGEN_S.
- **Tick generator:** a free-running prescaler emits a one-cycle tick every CLK_HZ cycles while `i_game_run`=1.
- **Countdown:** on a tick, every `RESPAWN` countdown decrements. When a countdown goes from 1 to 0, the block returns to `PRESENT` in the same cycle. Effective respawn delay is between (REGEN_S−1) s and REGEN_S s, because the first tick is asynchronous to the pickup.
- **Game stopped:** when `i_game_run`=0, all blocks are forced `PRESENT`, countdowns are 0, the prescaler is 0, the priority flag returns to car1, and no grants are issued. A drop of `i_game_run` mid-respawn takes effect on the next edge.
- **Standing on a block:** a car still overlapping a block at the moment it regenerates is granted on the next eligible cycle. This is intended.

## Timing
- **Registered outputs:** hits sampled at edge N produce `o_car*_grant` and the visibility drop at edge N+1. Latency is 1 cycle.
- **Grant pulses:** last exactly 1 cycle. `grant_idx` holds its last value otherwise; the consumer qualifies it with the grant.
- **Reset values:** `o_qblock_visible`=all ones, `o_car1_grant`=0, `o_car2_grant`=0, both `grant_idx`=0. Priority flag=car1, countdowns=0, prescaler=0.
- **Tick coinciding with a grant:** the new countdown loads REGEN_S and is not decremented in that cycle.
- **Regeneration coinciding with a hit:** a block regenerating at edge N is eligible for hits sampled at edge N. The earliest grant is at N+1.
- **Prescaler width:** $clog2(CLK_HZ). Terminal count is CLK_HZ−1, then it wraps to 0.

## Structure
- **game_pkg additions:**
  - `QBLOCK_NUM`, `QBLOCK_IDX_WIDTH`=2.
  - Reuse `QBLOCK_REGENERATE_INTERVAL` and `QBLOCK_REGENERATE_INTERVAL_WIDTH` as the defaults for REGEN_S.
  - `CLK_HZ` constant.
  - `typedef enum` `QblockState {QBLOCK_PRESENT, QBLOCK_RESPAWN}`.
- **Sub-module `qblock_tick_gen`:** the prescaler. Inputs are clock, reset and enable (`i_game_run`); output is the 1-cycle tick. Everything else stays in `qblock_arbiter`.

## Test plan
The bench uses CLK_HZ=10 and REGEN_S=3.
- **Reset and idle:** assert `i_rst` mid-run → visible=1111, no grants. Hits while `i_game_run`=0 → no grants, visible stays 1111.
- **Single pickup:** car1_hit=0100 for 1 cycle → next cycle car1_grant=1, idx=2, visible=1011. Block 2 returns within 20–30 cycles and never earlier.
- **Contention alternation:** car1_hit=car2_hit=0001 → car1 gets idx 0. After block 0 regenerates, repeat → car2 gets idx 0. Third repeat → car1.
- **Multi-hit and parallel:** car1_hit=1010 and car2_hit=0100 simultaneously → car1 idx 1 and car2 idx 2 in the same cycle. The next cycle car1 gets idx 3. visible ends at 0001.
- **Game stop mid-respawn:** pick block 3, then drop `i_game_run` 5 cycles later → visible=1111 next cycle. Raise `i_game_run` again → block 3 is immediately eligible.
- **Hold-over:** car2 holds hit=0010 continuously → grant idx 1 once, no further grants during respawn, then exactly one grant per regeneration.
